// File: rtl/pe_ctrl_seq_if.sv
// Handshake and control bundle between the PE datapath/host and the PE control sequencer.
// The master side issues job requests and operand/opsum handshakes; the slave side is the sequencer.
interface pe_ctrl_seq_if #(
    parameter int KW  = 8,
    parameter int CHW = 4
);
    logic           en;
    logic [KW-1:0]  kernel_size;
    logic [CHW-1:0] num_ch;
    logic           in_valid;
    logic           out_ready;
    logic           mult_seln;
    logic           acc_seln;
    logic           opsum_seln;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [KW-1:0]  mac_cnt;
    logic [CHW-1:0] ch_cnt;
    logic           cfg_err;
    logic [31:0]    stall_cnt;

    modport master (
        output en, kernel_size, num_ch, in_valid, out_ready,
        input  mult_seln, acc_seln, opsum_seln, in_ready, out_valid, busy,
               mac_cnt, ch_cnt, cfg_err, stall_cnt
    );

    modport slave (
        input  en, kernel_size, num_ch, in_valid, out_ready,
        output mult_seln, acc_seln, opsum_seln, in_ready, out_valid, busy,
               mac_cnt, ch_cnt, cfg_err, stall_cnt
    );
endinterface

// File: rtl/pe_ctrl_seq.sv
// PE control sequencer: IDLE -> IPSUM -> OP (K MACs x C channels) -> OPSUM, all outputs Moore-registered.
// Optional stall performance counter enabled by defining PE_CTRL_STALL_CNT_EN.
module pe_ctrl_seq #(
    parameter int KW  = 8,
    parameter int CHW = 4
) (
    input  logic         clk,
    input  logic         rst,
    pe_ctrl_seq_if.slave pe
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_IPSUM = 2'd1,
        S_OP    = 2'd2,
        S_OPSUM = 2'd3
    } state_t;

    // Bit order: mult_seln, acc_seln, opsum_seln, in_ready, out_valid, busy
    typedef struct packed {
        logic mult_seln;
        logic acc_seln;
        logic opsum_seln;
        logic in_ready;
        logic out_valid;
        logic busy;
    } ctl_t;

    localparam logic [KW-1:0]  K_ONE  = KW'(1'b1);
    localparam logic [CHW-1:0] C_ONE  = CHW'(1'b1);
    localparam logic [KW-1:0]  K_ZERO = {KW{1'b0}};
    localparam logic [CHW-1:0] C_ZERO = {CHW{1'b0}};

    function automatic ctl_t decode(input state_t s);
        ctl_t c;
        case (s)
            S_IDLE:  c = ctl_t'(6'b111000);
            S_IPSUM: c = ctl_t'(6'b111001);
            S_OP:    c = ctl_t'(6'b001101);
            S_OPSUM: c = ctl_t'(6'b000011);
            default: c = ctl_t'(6'b111000);
        endcase
        return c;
    endfunction

    state_t         r_state;
    ctl_t           r_ctl;
    logic [KW-1:0]  r_k;
    logic [CHW-1:0] r_c;
    logic [KW-1:0]  r_mac_cnt;
    logic [CHW-1:0] r_ch_cnt;
    logic           r_cfg_err;

    logic w_cfg_ok;
    logic w_mac_last;
    logic w_ch_last;

    // Latched K and C are non-zero whenever OP is active, so K-1 / C-1 never wrap.
    assign w_cfg_ok   = (pe.kernel_size != K_ZERO) && (pe.num_ch != C_ZERO);
    assign w_mac_last = (r_mac_cnt == (r_k - K_ONE));
    assign w_ch_last  = (r_ch_cnt == (r_c - C_ONE));

    // State register with next-state Moore decode so outputs flip on the same edge as the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ctl     <= decode(S_IDLE);
            r_k       <= K_ZERO;
            r_c       <= C_ZERO;
            r_mac_cnt <= K_ZERO;
            r_ch_cnt  <= C_ZERO;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (pe.en && w_cfg_ok) begin
                        r_k       <= pe.kernel_size;
                        r_c       <= pe.num_ch;
                        r_mac_cnt <= K_ZERO;
                        r_ch_cnt  <= C_ZERO;
                        r_state   <= S_IPSUM;
                        r_ctl     <= decode(S_IPSUM);
                    end else begin
                        r_cfg_err <= pe.en;
                        r_state   <= S_IDLE;
                        r_ctl     <= decode(S_IDLE);
                    end
                end
                S_IPSUM: begin
                    r_mac_cnt <= K_ZERO;
                    r_ch_cnt  <= C_ZERO;
                    r_state   <= S_OP;
                    r_ctl     <= decode(S_OP);
                end
                S_OP: begin
                    if (!pe.in_valid) begin
                        r_state <= S_OP;
                        r_ctl   <= decode(S_OP);
                    end else if (!w_mac_last) begin
                        r_mac_cnt <= r_mac_cnt + K_ONE;
                        r_state   <= S_OP;
                        r_ctl     <= decode(S_OP);
                    end else if (!w_ch_last) begin
                        // Channel rollover keeps accumulating; the ipsum is not reloaded.
                        r_mac_cnt <= K_ZERO;
                        r_ch_cnt  <= r_ch_cnt + C_ONE;
                        r_state   <= S_OP;
                        r_ctl     <= decode(S_OP);
                    end else begin
                        r_state <= S_OPSUM;
                        r_ctl   <= decode(S_OPSUM);
                    end
                end
                S_OPSUM: begin
                    if (!pe.out_ready) begin
                        r_state <= S_OPSUM;
                        r_ctl   <= decode(S_OPSUM);
                    end else if (pe.en && w_cfg_ok) begin
                        r_k       <= pe.kernel_size;
                        r_c       <= pe.num_ch;
                        r_mac_cnt <= K_ZERO;
                        r_ch_cnt  <= C_ZERO;
                        r_state   <= S_IPSUM;
                        r_ctl     <= decode(S_IPSUM);
                    end else begin
                        r_cfg_err <= pe.en;
                        r_state   <= S_IDLE;
                        r_ctl     <= decode(S_IDLE);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ctl   <= decode(S_IDLE);
                end
            endcase
        end
    end

    assign pe.mult_seln  = r_ctl.mult_seln;
    assign pe.acc_seln   = r_ctl.acc_seln;
    assign pe.opsum_seln = r_ctl.opsum_seln;
    assign pe.in_ready   = r_ctl.in_ready;
    assign pe.out_valid  = r_ctl.out_valid;
    assign pe.busy       = r_ctl.busy;
    assign pe.mac_cnt    = r_mac_cnt;
    assign pe.ch_cnt     = r_ch_cnt;
    assign pe.cfg_err    = r_cfg_err;

`ifdef PE_CTRL_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic        w_stall;

    assign w_stall = ((r_state == S_OP) && !pe.in_valid) ||
                     ((r_state == S_OPSUM) && !pe.out_ready);

    // Saturating stall counter, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end else begin
            r_stall_cnt <= r_stall_cnt;
        end
    end

    assign pe.stall_cnt = r_stall_cnt;
`else
    assign pe.stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pe_ctrl_seq.sv
// Self-checking bench for pe_ctrl_seq: per-cycle stimulus rows with expected observations
// pushed to a scoreboard queue before each edge and popped/compared after it.
module tb_pe_ctrl_seq;
    localparam int P_IDLE  = 0;
    localparam int P_IPSUM = 1;
    localparam int P_OP    = 2;
    localparam int P_OPSUM = 3;

    // Counters are ignored when mac < 0
    typedef struct {
        logic rst;
        logic en;
        int   k;
        int   c;
        logic iv;
        logic rdy;
        int   ph;
        int   mac;
        int   ch;
        logic cerr;
    } row_t;

    localparam logic [18:0] MASK_ALL = 19'h7FFFF;
    localparam logic [18:0] MASK_NC  = {6'h3F, 8'h00, 4'h0, 1'b1};

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    row_t exp_q[$];

    pe_ctrl_seq_if #(.KW(8), .CHW(4)) pe ();

    pe_ctrl_seq #(.KW(8), .CHW(4)) dut (
        .clk (clk),
        .rst (rst),
        .pe  (pe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {mult_seln, acc_seln, opsum_seln, in_ready, out_valid, busy} per state
    function automatic logic [5:0] ctl_of(input int ph);
        case (ph)
            P_IDLE:  return 6'b111000;
            P_IPSUM: return 6'b111001;
            P_OP:    return 6'b001101;
            P_OPSUM: return 6'b000011;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [18:0] obs();
        return {pe.mult_seln, pe.acc_seln, pe.opsum_seln, pe.in_ready, pe.out_valid,
                pe.busy, pe.mac_cnt, pe.ch_cnt, pe.cfg_err};
    endfunction

    function automatic logic [18:0] exp_vec(input row_t r);
        logic [7:0] m;
        logic [3:0] c;
        m = r.mac[7:0];
        c = r.ch[3:0];
        return {ctl_of(r.ph), m, c, r.cerr};
    endfunction

    task automatic drive(input row_t r);
        rst            = r.rst;
        pe.en          = r.en;
        pe.kernel_size = r.k[7:0];
        pe.num_ch      = r.c[3:0];
        pe.in_valid    = r.iv;
        pe.out_ready   = r.rdy;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        row_t rows[$];
        row_t cur;
        logic [18:0] mask;
        rows.push_back('{1'b1, 1'b1, 3, 1, 1'b1, 1'b1, P_IDLE, 0, 0, 1'b0});
        rows.push_back('{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, P_IDLE, 0, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 0, 0, 1'b0, 1'b0, P_IDLE, 0, 0, 1'b0});
        foreach (rows[i]) begin
            exp_q.push_back(rows[i]);
            drive(rows[i]);
            cur  = exp_q.pop_front();
            mask = (cur.mac < 0) ? MASK_NC : MASK_ALL;
            checks++;
            if ((obs() & mask) !== (exp_vec(cur) & mask)) begin
                errors++;
                $display("FAIL reset row %0d: got %h expected %h", i, obs() & mask, exp_vec(cur) & mask);
            end
        end
        checks++;
        if (pe.stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_stall: got %0d expected 0", pe.stall_cnt);
        end
    endtask

    task automatic test_single_ch();
        row_t rows[$];
        row_t cur;
        logic [18:0] mask;
        rows.push_back('{1'b0, 1'b1, 3, 1, 1'b1, 1'b1, P_IPSUM, 0, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b1, P_OP,    0, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b1, P_OP,    1, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b1, P_OP,    2, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b1, P_OPSUM, -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b1, P_IDLE,  -1, -1, 1'b0});
        foreach (rows[i]) begin
            exp_q.push_back(rows[i]);
            drive(rows[i]);
            cur  = exp_q.pop_front();
            mask = (cur.mac < 0) ? MASK_NC : MASK_ALL;
            checks++;
            if ((obs() & mask) !== (exp_vec(cur) & mask)) begin
                errors++;
                $display("FAIL single_ch row %0d: got %h expected %h", i, obs() & mask, exp_vec(cur) & mask);
            end
        end
    endtask

    task automatic test_multi_ch();
        row_t rows[$];
        row_t cur;
        logic [18:0] mask;
        rows.push_back('{1'b0, 1'b1, 2, 3, 1'b1, 1'b1, P_IPSUM, 0, 0, 1'b0});
        for (int b = 0; b < 6; b++)
            rows.push_back('{1'b0, 1'b0, 2, 3, 1'b1, 1'b1, P_OP, b % 2, b / 2, 1'b0});
        rows.push_back('{1'b0, 1'b0, 2, 3, 1'b1, 1'b1, P_OPSUM, -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b0, 2, 3, 1'b1, 1'b1, P_IDLE,  -1, -1, 1'b0});
        foreach (rows[i]) begin
            exp_q.push_back(rows[i]);
            drive(rows[i]);
            cur  = exp_q.pop_front();
            mask = (cur.mac < 0) ? MASK_NC : MASK_ALL;
            checks++;
            if ((obs() & mask) !== (exp_vec(cur) & mask)) begin
                errors++;
                $display("FAIL multi_ch row %0d: got %h expected %h", i, obs() & mask, exp_vec(cur) & mask);
            end
        end
    endtask

    task automatic test_stall();
        row_t rows[$];
        row_t cur;
        logic [18:0] mask;
        logic [31:0] exp_stall;
        rows.push_back('{1'b1, 1'b0, 0, 0, 1'b0, 1'b0, P_IDLE,  0, 0, 1'b0});
        rows.push_back('{1'b0, 1'b1, 3, 1, 1'b1, 1'b0, P_IPSUM, 0, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b0, P_OP,    0, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b0, P_OP,    1, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b0, 1'b0, P_OP,    1, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b0, 1'b0, P_OP,    1, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b0, P_OP,    2, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b0, P_OPSUM, -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b0, 1'b0, P_OPSUM, -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b0, 1'b0, P_OPSUM, -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b0, 1'b0, P_OPSUM, -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b0, 1'b1, P_IDLE,  -1, -1, 1'b0});
        foreach (rows[i]) begin
            exp_q.push_back(rows[i]);
            drive(rows[i]);
            cur  = exp_q.pop_front();
            mask = (cur.mac < 0) ? MASK_NC : MASK_ALL;
            checks++;
            if ((obs() & mask) !== (exp_vec(cur) & mask)) begin
                errors++;
                $display("FAIL stall row %0d: got %h expected %h", i, obs() & mask, exp_vec(cur) & mask);
            end
        end
`ifdef PE_CTRL_STALL_CNT_EN
        exp_stall = 32'd5;
`else
        exp_stall = 32'd0;
`endif
        checks++;
        if (pe.stall_cnt !== exp_stall) begin
            errors++;
            $display("FAIL stall_cnt: got %0d expected %0d", pe.stall_cnt, exp_stall);
        end
    endtask

    task automatic test_cfg_err();
        row_t rows[$];
        row_t cur;
        logic [18:0] mask;
        rows.push_back('{1'b0, 1'b1, 0, 1, 1'b0, 1'b1, P_IDLE,  -1, -1, 1'b1});
        rows.push_back('{1'b0, 1'b0, 0, 1, 1'b0, 1'b1, P_IDLE,  -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b1, 3, 0, 1'b0, 1'b1, P_IDLE,  -1, -1, 1'b1});
        rows.push_back('{1'b0, 1'b0, 3, 0, 1'b0, 1'b1, P_IDLE,  -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b1, 1, 1, 1'b1, 1'b0, P_IPSUM, 0, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 1, 1, 1'b1, 1'b0, P_OP,    0, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 1, 1, 1'b1, 1'b0, P_OPSUM, -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b1, 0, 1, 1'b0, 1'b1, P_IDLE,  -1, -1, 1'b1});
        rows.push_back('{1'b0, 1'b0, 0, 1, 1'b0, 1'b1, P_IDLE,  -1, -1, 1'b0});
        foreach (rows[i]) begin
            exp_q.push_back(rows[i]);
            drive(rows[i]);
            cur  = exp_q.pop_front();
            mask = (cur.mac < 0) ? MASK_NC : MASK_ALL;
            checks++;
            if ((obs() & mask) !== (exp_vec(cur) & mask)) begin
                errors++;
                $display("FAIL cfg_err row %0d: got %h expected %h", i, obs() & mask, exp_vec(cur) & mask);
            end
        end
    endtask

    task automatic test_abort();
        row_t rows[$];
        row_t cur;
        logic [18:0] mask;
        rows.push_back('{1'b0, 1'b1, 3, 1, 1'b1, 1'b1, P_IPSUM, 0, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b1, P_OP,    0, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b1, P_OP,    1, 0, 1'b0});
        rows.push_back('{1'b1, 1'b1, 3, 1, 1'b1, 1'b1, P_IDLE,  0, 0, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b1, P_IDLE,  -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b0, 3, 1, 1'b1, 1'b1, P_IDLE,  -1, -1, 1'b0});
        foreach (rows[i]) begin
            exp_q.push_back(rows[i]);
            drive(rows[i]);
            cur  = exp_q.pop_front();
            mask = (cur.mac < 0) ? MASK_NC : MASK_ALL;
            checks++;
            if ((obs() & mask) !== (exp_vec(cur) & mask)) begin
                errors++;
                $display("FAIL abort row %0d: got %h expected %h", i, obs() & mask, exp_vec(cur) & mask);
            end
        end
    endtask

    task automatic test_back_to_back();
        row_t rows[$];
        row_t cur;
        logic [18:0] mask;
        rows.push_back('{1'b0, 1'b1, 3, 1, 1'b1, 1'b1, P_IPSUM, 0, 0, 1'b0});
        for (int b = 0; b < 3; b++)
            rows.push_back('{1'b0, 1'b1, 5, 1, 1'b1, 1'b1, P_OP, b, 0, 1'b0});
        rows.push_back('{1'b0, 1'b1, 5, 1, 1'b1, 1'b1, P_OPSUM, -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b1, 5, 1, 1'b1, 1'b1, P_IPSUM, 0, 0, 1'b0});
        for (int b = 0; b < 5; b++)
            rows.push_back('{1'b0, 1'b1, 5, 1, 1'b1, 1'b1, P_OP, b, 0, 1'b0});
        rows.push_back('{1'b0, 1'b1, 5, 1, 1'b1, 1'b1, P_OPSUM, -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b0, 5, 1, 1'b1, 1'b1, P_IDLE,  -1, -1, 1'b0});
        foreach (rows[i]) begin
            exp_q.push_back(rows[i]);
            drive(rows[i]);
            cur  = exp_q.pop_front();
            mask = (cur.mac < 0) ? MASK_NC : MASK_ALL;
            checks++;
            if ((obs() & mask) !== (exp_vec(cur) & mask)) begin
                errors++;
                $display("FAIL back_to_back row %0d: got %h expected %h", i, obs() & mask, exp_vec(cur) & mask);
            end
        end
    endtask

    task automatic test_boundary();
        row_t rows[$];
        row_t cur;
        logic [18:0] mask;
        rows.push_back('{1'b0, 1'b1, 1, 15, 1'b1, 1'b1, P_IPSUM, 0, 0, 1'b0});
        for (int b = 0; b < 15; b++)
            rows.push_back('{1'b0, 1'b0, 1, 15, 1'b1, 1'b1, P_OP, 0, b, 1'b0});
        rows.push_back('{1'b0, 1'b0, 1, 15, 1'b1, 1'b1, P_OPSUM, -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b0, 1, 15, 1'b1, 1'b1, P_IDLE,  -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b1, 255, 2, 1'b1, 1'b1, P_IPSUM, 0, 0, 1'b0});
        for (int b = 0; b < 510; b++)
            rows.push_back('{1'b0, 1'b0, 255, 2, 1'b1, 1'b1, P_OP, b % 255, b / 255, 1'b0});
        rows.push_back('{1'b0, 1'b0, 255, 2, 1'b1, 1'b1, P_OPSUM, -1, -1, 1'b0});
        rows.push_back('{1'b0, 1'b0, 255, 2, 1'b1, 1'b1, P_IDLE,  -1, -1, 1'b0});
        foreach (rows[i]) begin
            exp_q.push_back(rows[i]);
            drive(rows[i]);
            cur  = exp_q.pop_front();
            mask = (cur.mac < 0) ? MASK_NC : MASK_ALL;
            checks++;
            if ((obs() & mask) !== (exp_vec(cur) & mask)) begin
                errors++;
                $display("FAIL boundary row %0d: got %h expected %h", i, obs() & mask, exp_vec(cur) & mask);
            end
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        pe.en          = 1'b0;
        pe.kernel_size = 8'd0;
        pe.num_ch      = 4'd0;
        pe.in_valid    = 1'b0;
        pe.out_ready   = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_single_ch();
        test_multi_ch();
        test_stall();
        test_cfg_err();
        test_abort();
        test_back_to_back();
        test_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
